// File: rtl/instruction_sequencer.sv
// instruction_sequencer: two-cycle fetch/execute control stage for the A/B/output register bank.
// Fetches 8-bit instructions ({opcode, Im}) from an external combinational ROM, decodes them,
// drives BUS and one load strobe during EXEC, and keeps the carry flag.
// Optional build macro SEQ_ILLEGAL_TRAP_EN: undefined opcodes enter a sticky TRAP state
// (TRAPPED output) instead of executing as NOP.
module instruction_sequencer #(
  parameter int unsigned PC_W     = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            CK,
  input  logic            RST_N,
  input  logic [7:0]      ROM_DATA,
  output logic [PC_W-1:0] ROM_ADDR,
  input  logic [3:0]      A_in,
  input  logic [3:0]      B_in,
  input  logic [3:0]      IN_PORT,
  input  logic            HALT,
  output logic [3:0]      BUS,
  output logic            LD_A,
  output logic            LD_B,
  output logic            LD_out,
`ifdef SEQ_ILLEGAL_TRAP_EN
  output logic            TRAPPED,
`endif
  output logic            C_FLAG
);

  localparam int unsigned DATA_W  = 4;
  localparam int unsigned INSTR_W = 8;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_TRAP  = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOVI_A = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOVI_B = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  state_t              r_state;
  state_t              w_state_next;
  logic [PC_W-1:0]     r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic                r_c;

  logic [3:0]          w_opcode;
  logic [DATA_W-1:0]   w_im;
  logic [DATA_W-1:0]   w_add_src;
  logic [DATA_W:0]     w_sum;
  logic [PC_W-1:0]     w_pc_next;
  logic                w_c_next;
  logic                w_commit;
`ifdef SEQ_ILLEGAL_TRAP_EN
  logic                w_undef;
`endif

  assign w_opcode = r_ir[7:4];
  assign w_im     = r_ir[3:0];
  assign ROM_ADDR = r_pc;
  assign C_FLAG   = r_c;

`ifdef SEQ_ILLEGAL_TRAP_EN
  // Undefined opcodes: 1000, 1010, 1100, 1101
  assign w_undef = (w_opcode == 4'b1000) || (w_opcode == 4'b1010) ||
                   (w_opcode == 4'b1100) || (w_opcode == 4'b1101);
`endif

  // Shared adder: B is the source only for ADD B,Im
  always_comb begin
    w_add_src = (w_opcode == OP_ADD_B) ? B_in : A_in;
    w_sum     = {1'b0, w_add_src} + {1'b0, w_im};
  end

  // State register
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) r_state <= S_FETCH;
    else        r_state <= w_state_next;
  end

  // Next-state logic; HALT only matters in FETCH so an executing instruction always completes
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH: if (!HALT) w_state_next = S_EXEC;
      S_EXEC: begin
        w_state_next = S_FETCH;
`ifdef SEQ_ILLEGAL_TRAP_EN
        if (w_undef) w_state_next = S_TRAP;
`endif
      end
`ifdef SEQ_ILLEGAL_TRAP_EN
      S_TRAP:  w_state_next = S_TRAP;
`endif
      default: w_state_next = S_FETCH;
    endcase
  end

  // Output decode: BUS and strobes are live only in EXEC
  always_comb begin
    BUS    = '0;
    LD_A   = 1'b0;
    LD_B   = 1'b0;
    LD_out = 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
    TRAPPED = (r_state == S_TRAP);
`endif
    if (r_state == S_EXEC) begin
      case (w_opcode)
        OP_ADD_A:  begin BUS = w_sum[DATA_W-1:0]; LD_A   = 1'b1; end
        OP_ADD_B:  begin BUS = w_sum[DATA_W-1:0]; LD_B   = 1'b1; end
        OP_MOVI_A: begin BUS = w_im;              LD_A   = 1'b1; end
        OP_MOVI_B: begin BUS = w_im;              LD_B   = 1'b1; end
        OP_MOV_AB: begin BUS = B_in;              LD_A   = 1'b1; end
        OP_MOV_BA: begin BUS = A_in;              LD_B   = 1'b1; end
        OP_IN_A:   begin BUS = IN_PORT;           LD_A   = 1'b1; end
        OP_IN_B:   begin BUS = IN_PORT;           LD_B   = 1'b1; end
        OP_OUT_B:  begin BUS = B_in;              LD_out = 1'b1; end
        OP_OUT_I:  begin BUS = w_im;              LD_out = 1'b1; end
        default:   ;
      endcase
    end
  end

  // Execute results: next PC (jumps or sequential wrap) and next carry; JNC sees the old carry
  always_comb begin
    w_pc_next = r_pc + PC_W'(1);
    w_c_next  = 1'b0;
    case (w_opcode)
      OP_ADD_A, OP_ADD_B: w_c_next = w_sum[DATA_W];
      OP_JMP:             w_pc_next = PC_W'(w_im);
      OP_JNC:             if (!r_c) w_pc_next = PC_W'(w_im);
      default:            ;
    endcase
    w_commit = (r_state == S_EXEC);
`ifdef SEQ_ILLEGAL_TRAP_EN
    if (w_undef) w_commit = 1'b0;
`endif
  end

  // PC, IR and carry registers
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      r_pc <= PC_W'(RESET_PC);
      r_ir <= '0;
      r_c  <= 1'b0;
    end else begin
      if (r_state == S_FETCH && !HALT) r_ir <= ROM_DATA;
      if (w_commit) begin
        r_pc <= w_pc_next;
        r_c  <= w_c_next;
      end
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Testbench for instruction_sequencer: ROM and register bank models around the DUT,
// a vector table, hand-written sequences and a randomized program run against a reference model.
module tb_instruction_sequencer;

  logic       CK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] ROM_DATA;
  logic [3:0] ROM_ADDR;
  logic [3:0] A_in, B_in;
  logic [3:0] IN_PORT = 4'h0;
  logic       HALT = 1'b0;
  logic [3:0] BUS;
  logic       LD_A, LD_B, LD_out;
  logic       C_FLAG;
`ifdef SEQ_ILLEGAL_TRAP_EN
  logic       TRAPPED;
`endif

  logic [7:0] rom [16];
  logic [3:0] a_reg = 4'h0, b_reg = 4'h0, out_reg = 4'h0;
  logic       use_ovr = 1'b0;
  logic [3:0] ovr_a = 4'h0, ovr_b = 4'h0;

  int n_chk = 0;
  int n_err = 0;

  instruction_sequencer dut (
    .CK(CK), .RST_N(RST_N), .ROM_DATA(ROM_DATA), .ROM_ADDR(ROM_ADDR),
    .A_in(A_in), .B_in(B_in), .IN_PORT(IN_PORT), .HALT(HALT), .BUS(BUS),
    .LD_A(LD_A), .LD_B(LD_B), .LD_out(LD_out),
`ifdef SEQ_ILLEGAL_TRAP_EN
    .TRAPPED(TRAPPED),
`endif
    .C_FLAG(C_FLAG)
  );

  assign ROM_DATA = rom[ROM_ADDR];
  assign A_in = use_ovr ? ovr_a : a_reg;
  assign B_in = use_ovr ? ovr_b : b_reg;

  always #5 CK = ~CK;

  // Register bank: loads on the rising edge that ends EXEC
  always @(posedge CK) begin
    if (LD_A)   a_reg   <= BUS;
    if (LD_B)   b_reg   <= BUS;
    if (LD_out) out_reg <= BUS;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] ins;
    logic [3:0] a, b, inp;
    int         ld;   // 1=LD_A 2=LD_B 4=LD_out 0=none
    int         bus;
    int         c;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int ld_code();
    return int'({LD_out, LD_B, LD_A});
  endfunction

  // One instruction from FETCH: check strobe/BUS in EXEC, then PC and carry afterwards
  task automatic exec_check(input string nm, input int e_ld, input int e_bus,
                            input int e_pc, input int e_c);
    @(posedge CK); #1;
    chk({nm, " ld"}, ld_code(), e_ld);
    chk({nm, " bus"}, int'(BUS), e_bus);
    @(posedge CK); #1;
    chk({nm, " pc"}, int'(ROM_ADDR), e_pc);
    chk({nm, " c"}, int'(C_FLAG), e_c);
  endtask

  task automatic do_reset();
    HALT  = 1'b0;
    RST_N = 1'b0;
    repeat (2) @(posedge CK);
    #1 RST_N = 1'b1;
  endtask

  // Instruction-set reference: effect of one instruction on strobes, BUS, PC and carry
  function automatic void model_step(input int ins, input int a, input int b, input int inp,
                                     input int c, input int pc, output int ld, output int bus,
                                     output int npc, output int nc);
    int op = ins / 16;
    int im = ins % 16;
    ld = 0; bus = 0; nc = 0; npc = (pc + 1) % 16;
    case (op)
      0:  begin bus = (a + im) % 16; nc = (a + im) / 16; ld = 1; end
      5:  begin bus = (b + im) % 16; nc = (b + im) / 16; ld = 2; end
      3:  begin bus = im;  ld = 1; end
      7:  begin bus = im;  ld = 2; end
      1:  begin bus = b;   ld = 1; end
      4:  begin bus = a;   ld = 2; end
      2:  begin bus = inp; ld = 1; end
      6:  begin bus = inp; ld = 2; end
      9:  begin bus = b;   ld = 4; end
      11: begin bus = im;  ld = 4; end
      15: npc = im;
      14: if (c == 0) npc = im;
      default: ;
    endcase
  endfunction

  initial begin
    vec_t vecs[$];
    int   m_pc, m_c, e_ld, e_bus, e_pc, e_c, pc0;
    logic [7:0] ins;

    for (int i = 0; i < 16; i++) rom[i] = 8'h00;

    // Reset asserted mid-EXEC of MOV A,5
    rom[0] = 8'h35;
    do_reset();
    chk("rst pc", int'(ROM_ADDR), 0);
    chk("rst c", int'(C_FLAG), 0);
    @(posedge CK); #1;
    chk("pre-abort ld", ld_code(), 1);
    chk("pre-abort bus", int'(BUS), 5);
    RST_N = 1'b0;
    #1;
    chk("abort ld", ld_code(), 0);
    chk("abort bus", int'(BUS), 0);
    @(posedge CK); #1;
    chk("abort no load", int'(a_reg), 0);
    #3 RST_N = 1'b1;
    chk("post-rst pc", int'(ROM_ADDR), 0);
    chk("post-rst c", int'(C_FLAG), 0);
    chk("post-rst bus", int'(BUS), 0);

    // MOV/ADD with carry, then JNC not taken / taken, JMP
    rom[0] = 8'h3A; rom[1] = 8'h07; rom[2] = 8'hE5; rom[3] = 8'hE5; rom[5] = 8'hF0;
    exec_check("mov_a_im", 1, 10, 1, 0);
    exec_check("add_a_im", 1, 1, 2, 1);
    exec_check("jnc_not_taken", 0, 0, 3, 0);
    exec_check("jnc_taken", 0, 0, 5, 0);
    exec_check("jmp", 0, 0, 0, 0);

    // IN / MOV B,A / OUT
    rom[0] = 8'h20; rom[1] = 8'h40; rom[2] = 8'h90; rom[3] = 8'hBC;
    IN_PORT = 4'h6;
    exec_check("in_a", 1, 6, 1, 0);
    exec_check("mov_b_a", 2, 6, 2, 0);
    exec_check("out_b", 4, 6, 3, 0);
    exec_check("out_im", 4, 12, 4, 0);
    chk("out_reg", int'(out_reg), 12);

    // Carry set, then HALT freezes for 5 cycles
    rom[4] = 8'h0F; rom[5] = 8'h7E; rom[6] = 8'hFF; rom[15] = 8'h31;
    exec_check("add_carry", 1, 5, 5, 1);
    HALT = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge CK); #1;
      chk("halt ld", ld_code(), 0);
      chk("halt pc", int'(ROM_ADDR), 5);
      chk("halt c", int'(C_FLAG), 1);
    end
    HALT = 1'b0;
    exec_check("after_halt", 2, 14, 6, 0);
    exec_check("jmp_15", 0, 0, 15, 0);
    exec_check("wrap", 1, 1, 0, 0);

    // Undefined opcode after a carry-setting ADD
    rom[0] = 8'h0F; rom[1] = 8'h85;
    exec_check("add_wrap", 1, 0, 1, 1);
`ifdef SEQ_ILLEGAL_TRAP_EN
    @(posedge CK); #1;
    chk("trap exec ld", ld_code(), 0);
    for (int k = 0; k < 5; k++) begin
      @(posedge CK); #1;
      chk("trapped", int'(TRAPPED), 1);
      chk("trap pc", int'(ROM_ADDR), 1);
      chk("trap c", int'(C_FLAG), 1);
      chk("trap ld", ld_code(), 0);
    end
    do_reset();
    chk("trap cleared", int'(TRAPPED), 0);
    chk("trap rst pc", int'(ROM_ADDR), 0);
`else
    exec_check("undef_nop", 0, 0, 2, 0);
`endif

    // Vector table: one instruction each with forced operands
    vecs.push_back('{8'h07, 4'd9, 4'd0, 4'd0, 1, 0, 1});
`ifndef SEQ_ILLEGAL_TRAP_EN
    vecs.push_back('{8'h85, 4'd0, 4'd0, 4'd0, 0, 0, 0});
`endif
    vecs.push_back('{8'h03, 4'd2, 4'd0, 4'd0, 1, 5, 0});
    vecs.push_back('{8'h5F, 4'd0, 4'd1, 4'd0, 2, 0, 1});
    vecs.push_back('{8'h3A, 4'd0, 4'd0, 4'd0, 1, 10, 0});
    vecs.push_back('{8'h54, 4'd0, 4'd3, 4'd0, 2, 7, 0});
    vecs.push_back('{8'h7C, 4'd0, 4'd0, 4'd0, 2, 12, 0});
    vecs.push_back('{8'h12, 4'd2, 4'd13, 4'd0, 1, 13, 0});
    vecs.push_back('{8'h49, 4'd14, 4'd0, 4'd0, 2, 14, 0});
    vecs.push_back('{8'h23, 4'd0, 4'd0, 4'd6, 1, 6, 0});
    vecs.push_back('{8'h6F, 4'd0, 4'd0, 4'd9, 2, 9, 0});
    vecs.push_back('{8'h94, 4'd0, 4'd4, 4'd0, 4, 4, 0});
    vecs.push_back('{8'hB3, 4'd0, 4'd0, 4'd0, 4, 3, 0});
    vecs.push_back('{8'h5C, 4'd0, 4'd9, 4'd0, 2, 5, 1});
`ifndef SEQ_ILLEGAL_TRAP_EN
    vecs.push_back('{8'hAF, 4'd0, 4'd0, 4'd0, 0, 0, 0});
`endif
    do_reset();
    use_ovr = 1'b1;
    foreach (vecs[i]) begin
      ovr_a   = vecs[i].a;
      ovr_b   = vecs[i].b;
      IN_PORT = vecs[i].inp;
      pc0     = int'(ROM_ADDR);
      rom[pc0] = vecs[i].ins;
      exec_check($sformatf("vec%0d", i), vecs[i].ld, vecs[i].bus, (pc0 + 1) % 16, vecs[i].c);
    end
    use_ovr = 1'b0;

    // Random program against the reference model, with random HALT stalls
    do_reset();
    m_pc = 0;
    m_c  = 0;
    for (int i = 0; i < 16; i++) begin
      ins = 8'($urandom);
`ifdef SEQ_ILLEGAL_TRAP_EN
      if (ins[7:4] == 4'h8 || ins[7:4] == 4'hA || ins[7:4] == 4'hC || ins[7:4] == 4'hD)
        ins[7] = 1'b0;
`endif
      rom[i] = ins;
    end
    for (int n = 0; n < 300; n++) begin
      IN_PORT = 4'($urandom);
      if ($urandom_range(3) == 0) begin
        HALT = 1'b1;
        repeat ($urandom_range(3, 1)) begin
          @(posedge CK); #1;
          chk("rand halt ld", ld_code(), 0);
          chk("rand halt pc", int'(ROM_ADDR), m_pc);
          chk("rand halt c", int'(C_FLAG), m_c);
        end
        HALT = 1'b0;
      end
      model_step(int'(rom[m_pc]), int'(a_reg), int'(b_reg), int'(IN_PORT), m_c, m_pc,
                 e_ld, e_bus, e_pc, e_c);
      exec_check($sformatf("rand%0d ins=%02h", n, rom[m_pc]), e_ld, e_bus, e_pc, e_c);
      m_pc = e_pc;
      m_c  = e_c;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
